// File: rtl/hazard_stall_control_if.sv
// Pipeline-side bundle for hazard_stall_control: decoded latches, branch/multdiv status in;
// stall/flush/bubble controls, multdiv handshake and perf counters out.
interface hazard_stall_control_if;
  logic [31:0] fd_ir;
  logic [31:0] dx_ir;
  logic        take_branch;
  logic        md_ready;
  logic        md_start;
  logic        md_is_div;
  logic        md_busy;
  logic        stall_pc;
  logic        stall_fd;
  logic        stall_dx;
  logic        flush_fd;
  logic        flush_dx;
  logic        bubble_xm;
  logic        xm_from_md;
  logic        md_error;
  logic [31:0] stall_cycles;
  logic [15:0] md_count;

  modport master (
    output fd_ir, dx_ir, take_branch, md_ready,
    input  md_start, md_is_div, md_busy, stall_pc, stall_fd, stall_dx,
    input  flush_fd, flush_dx, bubble_xm, xm_from_md, md_error, stall_cycles, md_count
  );

  modport slave (
    input  fd_ir, dx_ir, take_branch, md_ready,
    output md_start, md_is_div, md_busy, stall_pc, stall_fd, stall_dx,
    output flush_fd, flush_dx, bubble_xm, xm_from_md, md_error, stall_cycles, md_count
  );
endinterface

// File: rtl/hazard_stall_control.sv
// Load-use interlock, mul/div sequencing (k+3 DX cycles for ready k after start) and branch flush;
// stalls/flushes are same-cycle combinational. Perf counters exist only with STALL_PERF_EN defined.
module hazard_stall_control #(
  parameter int MD_TIMEOUT = 40,
  parameter int MD_CNT_W   = 6
) (
  input logic              clock,
  input logic              reset_n,
  hazard_stall_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MD_ISSUE, MD_WAIT, MD_DONE} state_t;

  state_t                state;
  logic [MD_CNT_W-1:0]   wait_cnt;
  logic                  md_is_div_q;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic       rd_used, rs_used, rt_used;
  logic       load_use, md_op, timeout_hit;
  logic       in_idle, br_c, md_det_c, lu_c, md_hold_c;
  logic       stall_pc_c, md_start_c;
  logic       unused_bits;

  assign fd_op    = bus.fd_ir[31:27];
  assign fd_rd    = bus.fd_ir[26:22];
  assign fd_rs    = bus.fd_ir[21:17];
  assign fd_rt    = bus.fd_ir[16:12];
  assign dx_op    = bus.dx_ir[31:27];
  assign dx_rd    = bus.dx_ir[26:22];
  assign dx_aluop = bus.dx_ir[6:2];
  assign unused_bits = ^{bus.fd_ir[11:0], bus.dx_ir[21:7], bus.dx_ir[1:0]};

  // Store data (rd of sw) is not a source here: the W->M memory bypass covers it.
  always_comb begin
    rd_used = 1'b0;
    rs_used = 1'b0;
    rt_used = 1'b0;
    case (fd_op)
      5'd0:             begin rs_used = 1'b1; rt_used = 1'b1; end
      5'd5, 5'd7, 5'd8: rs_used = 1'b1;
      5'd2, 5'd6:       begin rd_used = 1'b1; rs_used = 1'b1; end
      5'd4:             rd_used = 1'b1;
      default:          ;
    endcase
  end

  assign load_use = (dx_op == 5'd8) && (dx_rd != 5'd0) &&
                    ((rd_used && (fd_rd == dx_rd)) ||
                     (rs_used && (fd_rs == dx_rd)) ||
                     (rt_used && (fd_rt == dx_rd)));
  assign md_op       = (dx_op == 5'd0) && ((dx_aluop == 5'd6) || (dx_aluop == 5'd7));
  assign timeout_hit = (wait_cnt == MD_CNT_W'(MD_TIMEOUT - 1));

  assign in_idle    = (state == IDLE);
  assign br_c       = in_idle && bus.take_branch;
  assign md_det_c   = in_idle && !bus.take_branch && md_op;
  assign lu_c       = in_idle && !bus.take_branch && !md_op && load_use;
  assign md_hold_c  = md_det_c || (state == MD_ISSUE) || (state == MD_WAIT);
  assign stall_pc_c = md_hold_c || lu_c;
  assign md_start_c = (state == MD_ISSUE);

  // md_is_div is captured on entry to MD_ISSUE so it is valid alongside md_start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      md_is_div_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_det_c) begin
            state       <= MD_ISSUE;
            md_is_div_q <= dx_aluop[0];
          end
        end
        MD_ISSUE: begin
          state    <= MD_WAIT;
          wait_cnt <= '0;
        end
        MD_WAIT: begin
          wait_cnt <= wait_cnt + MD_CNT_W'(1);
          if (bus.md_ready || timeout_hit) state <= MD_DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is qualified by reset_n so nothing leaks while reset is asserted.
  assign bus.md_start   = reset_n && md_start_c;
  assign bus.md_is_div  = reset_n && md_is_div_q;
  assign bus.md_busy    = reset_n && !in_idle;
  assign bus.stall_pc   = reset_n && stall_pc_c;
  assign bus.stall_fd   = reset_n && stall_pc_c;
  assign bus.stall_dx   = reset_n && md_hold_c;
  assign bus.flush_fd   = reset_n && br_c;
  assign bus.flush_dx   = reset_n && (br_c || lu_c);
  assign bus.bubble_xm  = reset_n && md_hold_c;
  assign bus.xm_from_md = reset_n && (state == MD_DONE);
  assign bus.md_error   = reset_n && (state == MD_WAIT) && !bus.md_ready && timeout_hit;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] md_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      md_cnt    <= '0;
    end else begin
      if (stall_pc_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (md_start_c) md_cnt <= md_cnt + 16'd1;
    end
  end

  assign bus.stall_cycles = reset_n ? stall_cnt : '0;
  assign bus.md_count     = reset_n ? md_cnt    : '0;
`else
  assign bus.stall_cycles = '0;
  assign bus.md_count     = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Scoreboarded bench for hazard_stall_control: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_stall_control;

  logic clock;
  logic reset_n;

  hazard_stall_control_if bus ();

  hazard_stall_control #(.MD_TIMEOUT(8), .MD_CNT_W(6)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef STALL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Output vector: {md_start, md_is_div, md_busy, stall_pc, stall_fd, stall_dx,
  //                 flush_fd, flush_dx, bubble_xm, xm_from_md, md_error}
  localparam logic [10:0] ST = 11'h400, DV = 11'h200, BZ = 11'h100, SP = 11'h080;
  localparam logic [10:0] SF = 11'h040, SD = 11'h020, FF = 11'h010, FX = 11'h008;
  localparam logic [10:0] BX = 11'h004, XM = 11'h002, ER = 11'h001;
  localparam logic [10:0] LU = SP | SF | FX;
  localparam logic [10:0] S4 = SP | SF | SD | BX;
  localparam logic [10:0] NM = 11'h000;

  typedef struct {
    int          id;
    logic [10:0] exp;
    logic [10:0] mask;
    logic [31:0] exp_sc;
    logic [15:0] exp_mc;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_id   = 0;
  logic [31:0] acc_sc = '0;
  logic [15:0] acc_mc = '0;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] aluop);
    return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  task automatic drive(input logic rn, input logic [31:0] fd, input logic [31:0] dx,
                       input logic tb_in, input logic rdy,
                       input logic [10:0] exp, input logic [10:0] mask);
    ent_t e;
    reset_n         = rn;
    bus.fd_ir       = fd;
    bus.dx_ir       = dx;
    bus.take_branch = tb_in;
    bus.md_ready    = rdy;
    e.id     = vec_id;
    e.exp    = exp;
    e.mask   = mask;
    e.exp_sc = (PERF_EN && rn) ? acc_sc : 32'd0;
    e.exp_mc = (PERF_EN && rn) ? acc_mc : 16'd0;
    sb.push_back(e);
    vec_id++;
    if (!rn) begin
      acc_sc = '0;
      acc_mc = '0;
    end else begin
      if (exp[7])  acc_sc = acc_sc + 32'd1;
      if (exp[10]) acc_mc = acc_mc + 16'd1;
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    ent_t e;
    logic [10:0] act;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act = {bus.md_start, bus.md_is_div, bus.md_busy, bus.stall_pc, bus.stall_fd,
             bus.stall_dx, bus.flush_fd, bus.flush_dx, bus.bubble_xm, bus.xm_from_md,
             bus.md_error};
      n_checks++;
      if ((act & ~e.mask) !== (e.exp & ~e.mask)) begin
        n_fail++;
        $display("FAIL vec%0d ctrl: got %b want %b (ignored bits %b)", e.id, act, e.exp, e.mask);
      end
      n_checks++;
      if ((bus.stall_cycles !== e.exp_sc) || (bus.md_count !== e.exp_mc)) begin
        n_fail++;
        $display("FAIL vec%0d perf: got stall_cycles=%0d md_count=%0d want %0d/%0d",
                 e.id, bus.stall_cycles, bus.md_count, e.exp_sc, e.exp_mc);
      end
    end
  end

  logic [31:0] nop, lw3, lw0, add_rs3, add_rt3, add_rs0, sw_rd3, sw_rs3, addi_rt3;
  logic [31:0] br_rd3, jr_rd3, jr_rs3, lw_rs3, mul9, div9, beq3;

  initial begin
    nop      = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    lw3      = mk(5'd8, 5'd3, 5'd1, 5'd0, 5'd0);
    lw0      = mk(5'd8, 5'd0, 5'd1, 5'd0, 5'd0);
    add_rs3  = mk(5'd0, 5'd5, 5'd3, 5'd4, 5'd0);
    add_rt3  = mk(5'd0, 5'd5, 5'd1, 5'd3, 5'd0);
    add_rs0  = mk(5'd0, 5'd5, 5'd0, 5'd4, 5'd0);
    sw_rd3   = mk(5'd7, 5'd3, 5'd6, 5'd0, 5'd0);
    sw_rs3   = mk(5'd7, 5'd6, 5'd3, 5'd0, 5'd0);
    addi_rt3 = mk(5'd5, 5'd7, 5'd1, 5'd3, 5'd0);
    br_rd3   = mk(5'd2, 5'd3, 5'd1, 5'd0, 5'd0);
    jr_rd3   = mk(5'd4, 5'd3, 5'd0, 5'd0, 5'd0);
    jr_rs3   = mk(5'd4, 5'd0, 5'd3, 5'd0, 5'd0);
    lw_rs3   = mk(5'd8, 5'd9, 5'd3, 5'd0, 5'd0);
    mul9     = mk(5'd0, 5'd9, 5'd1, 5'd2, 5'd6);
    div9     = mk(5'd0, 5'd9, 5'd1, 5'd2, 5'd7);
    beq3     = mk(5'd6, 5'd3, 5'd4, 5'd0, 5'd0);

    reset_n = 1'b0;
    bus.fd_ir = nop; bus.dx_ir = nop; bus.take_branch = 1'b0; bus.md_ready = 1'b0;
    @(posedge clock);
    #1;

    // Reset holds everything low even with a live hazard/branch on the inputs.
    drive(0, add_rs3, lw3, 0, 0, NM, NM);
    drive(0, add_rs3, mul9, 1, 1, NM, NM);

    // Load-use interlock and source-field decoding
    drive(1, add_rs3, lw3, 0, 0, LU, NM);
    drive(1, nop, add_rs3, 0, 0, NM, NM);
    drive(1, sw_rd3, lw3, 0, 0, NM, NM);
    drive(1, sw_rs3, lw3, 0, 0, LU, NM);
    drive(1, add_rt3, lw3, 0, 0, LU, NM);
    drive(1, add_rs0, lw0, 0, 0, NM, NM);
    drive(1, addi_rt3, lw3, 0, 0, NM, NM);
    drive(1, br_rd3, lw3, 0, 0, LU, NM);
    drive(1, jr_rd3, lw3, 0, 0, LU, NM);
    drive(1, jr_rs3, lw3, 0, 0, NM, NM);
    drive(1, lw_rs3, lw3, 0, 0, LU, NM);

    // mul, ready 5 cycles after md_start; stray ready/branch outside IDLE/WAIT ignored
    drive(1, nop, mul9, 0, 1, S4, NM);
    drive(1, nop, mul9, 0, 1, S4 | ST | BZ, DV);
    drive(1, nop, mul9, 0, 0, S4 | BZ, NM);
    drive(1, nop, mul9, 0, 0, S4 | BZ, NM);
    drive(1, nop, mul9, 1, 0, S4 | BZ, NM);
    drive(1, nop, mul9, 0, 0, S4 | BZ, NM);
    drive(1, nop, mul9, 0, 1, S4 | BZ, NM);
    drive(1, nop, mul9, 0, 1, XM | BZ, NM);
    drive(1, nop, nop, 0, 0, NM, NM);

    // div with md_ready held low: error on the 8th wait cycle
    drive(1, nop, div9, 0, 0, S4, NM);
    drive(1, nop, div9, 0, 0, S4 | ST | BZ, DV);
    for (int i = 0; i < 7; i++) drive(1, nop, div9, 0, 0, S4 | BZ | DV, NM);
    drive(1, nop, div9, 0, 0, S4 | BZ | DV | ER, NM);
    drive(1, nop, div9, 0, 0, XM | BZ | DV, NM);
    drive(1, nop, nop, 0, 0, DV, NM);

    // ready coinciding with the timeout cycle: no error
    drive(1, nop, div9, 0, 0, S4 | DV, NM);
    drive(1, nop, div9, 0, 0, S4 | ST | BZ, DV);
    for (int i = 0; i < 7; i++) drive(1, nop, div9, 0, 0, S4 | BZ | DV, NM);
    drive(1, nop, div9, 0, 1, S4 | BZ | DV, NM);
    drive(1, nop, div9, 0, 0, XM | BZ | DV, NM);
    drive(1, nop, nop, 0, 0, DV, NM);

    // taken branch outranks load-use and md issue
    drive(1, add_rs3, beq3, 1, 0, FF | FX | DV, NM);
    drive(1, add_rs3, lw3, 1, 0, FF | FX | DV, NM);
    drive(1, nop, mul9, 1, 0, FF | FX | DV, NM);
    drive(1, nop, nop, 0, 0, DV, NM);

    // async reset during MD_WAIT, then fresh detection required
    drive(1, nop, div9, 0, 0, S4 | DV, NM);
    drive(1, nop, div9, 0, 0, S4 | ST | BZ, DV);
    drive(1, nop, div9, 0, 0, S4 | BZ | DV, NM);
    drive(1, nop, div9, 0, 0, S4 | BZ | DV, NM);
    drive(0, nop, div9, 0, 0, NM, NM);
    drive(0, nop, div9, 0, 1, NM, NM);
    drive(1, nop, nop, 0, 0, NM, NM);
    drive(1, add_rs3, lw3, 0, 0, LU, NM);
    drive(1, nop, mul9, 0, 0, S4, NM);
    drive(1, nop, mul9, 0, 0, S4 | ST | BZ, NM);
    drive(1, nop, mul9, 0, 0, S4 | BZ, NM);

    repeat (2) @(posedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_control.md
Name: hazard_stall_control

Overview:
- Pipeline sequencing controller for the 5-stage core; sits beside the operand bypass logic.
- Handles the hazards bypassing cannot cover:
  - load-use interlock (FD vs DX);
  - multi-cycle mul/div sequencing (issue, wait, writeback hand-off);
  - control-flow flush on taken branch/jump.
- Drives pipeline-register enables/flushes and the multdiv unit start handshake.

Parameters:
MD_TIMEOUT, 40, max MD_WAIT cycles before forced completion with error
MD_CNT_W, 6, width of wait counter (must hold MD_TIMEOUT-1)

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
fd_ir  in  32  instruction in F/D latch
dx_ir  in  32  instruction in D/X latch
take_branch  in  1  taken branch/jump resolved for DX instruction this cycle
md_ready  in  1  multdiv result valid (level, sampled in MD_WAIT)
md_start  out  1  one-cycle start pulse to multdiv
md_is_div  out  1  operation select latched at issue (1=div)
md_busy  out  1  state != IDLE
stall_pc  out  1  hold PC
stall_fd  out  1  hold F/D latch
stall_dx  out  1  hold D/X latch
flush_fd  out  1  load nop into F/D next edge
flush_dx  out  1  load nop into D/X next edge
bubble_xm  out  1  load nop into X/M next edge
xm_from_md  out  1  X/M result mux selects multdiv result
md_error  out  1  one-cycle pulse on timeout
stall_cycles  out  32  perf counter (see Optional Feature)
md_count  out  16  perf counter (see Optional Feature)

Behaviour:
- Fields: op[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2]. Opcodes: 0 ALU, 5 addi, 7 sw, 8 lw, 2/6 branch, 4 jr. aluop 6 = mul, 7 = div.
- Reset (reset_n low, async): state IDLE, counter 0, md_is_div 0, perf counters 0. All outputs forced 0 while reset_n is low, including combinational ones.
- FD source regs:
  - ALU: rs, rt.
  - addi/lw: rs.
  - sw: rs only. Store-data (rd) hazards are covered by W->M memory bypass; no stall.
  - branch 2/6: rd, rs.
  - jr: rd.
  - Other opcodes read nothing.
- load_use = dx op==8 AND dx rd!=0 AND dx rd equals any FD source reg.
- md_op = dx op==0 AND aluop in {6,7}.
- FSM states IDLE, MD_ISSUE, MD_WAIT, MD_DONE.
- IDLE, priority take_branch > md_op > load_use:
  - take_branch: flush_fd=flush_dx=1 same cycle (combinational); no MD issue; stay IDLE.
  - md_op: stall_pc=stall_fd=stall_dx=bubble_xm=1 same cycle; next state MD_ISSUE.
  - load_use: stall_pc=stall_fd=flush_dx=1 for exactly one cycle. The lw advances; the next cycle re-evaluates with bypass available.
- MD_ISSUE (1 cycle):
  - md_start=1; md_is_div registered <= aluop[0].
  - Stalls as above; counter cleared.
  - Next state MD_WAIT.
- MD_WAIT:
  - Stalls held; counter increments each cycle.
  - md_ready=1 -> MD_DONE.
  - Else if counter==MD_TIMEOUT-1 -> md_error=1 this cycle, next state MD_DONE.
  - md_ready and timeout in the same cycle: ready wins, no error.
- MD_DONE (1 cycle):
  - No stalls; xm_from_md=1; DX instruction advances to X/M.
  - Next state IDLE. No re-trigger, since DX holds a new instruction next cycle.
- take_branch, load_use and md_op are ignored outside IDLE.
- md_ready outside MD_WAIT is ignored.
- Latency: mul/div with ready k cycles after md_start occupies DX for k+3 cycles (IDLE detect + ISSUE + k WAIT + DONE).
- Reset mid-operation: immediate return to IDLE. md_start is not re-issued until md_op is detected again after reset release.

Optional Feature:
STALL_PERF_EN:
- Defined:
  - stall_cycles increments each cycle stall_pc=1, saturating at all-ones.
  - md_count increments on each md_start, wrapping modulo 2^16.
  - Both cleared by reset_n.
- Undefined: both outputs tied to 0 and no counter flops exist.

Test Plan:
- DX lw r3 (op 8, rd 3), FD add r5,r3,r4 (rs 3) -> stall_pc=stall_fd=flush_dx=1 for one cycle, then 0 with FD advancing.
- DX lw r3; FD sw with rd=3, rs=6 -> no stall. FD sw with rs=3 -> one-cycle stall. DX lw r0 with FD add rs=0 -> no stall.
- DX mul (op 0, aluop 6), md_ready asserted 5 cycles after md_start:
  - md_start pulses once; stalls for 1+1+5 cycles; xm_from_md=1 for 1 cycle; md_is_div=0.
- MD_TIMEOUT=8, DX div, md_ready held 0:
  - md_error pulses on the 8th MD_WAIT cycle; MD_DONE follows; md_is_div=1.
- take_branch=1 while DX branch and FD add reads the branch rd -> flush_fd=flush_dx=1, stall_pc=0.
- reset_n low during MD_WAIT:
  - all outputs 0 immediately (asynchronous); md_busy=0.
  - With STALL_PERF_EN: stall_cycles=0 and md_count=0 after reset.
